// File: rtl/rr_mux_arb_if.sv
// rr_mux_arb_if: channel-side and consumer-side handshake bundle for rr_mux_arb.
interface rr_mux_arb_if #(
    parameter int W  = 5,
    parameter int N  = 4,
    parameter int SW = 2
);
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic           lock;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_ready;
    modport master (output in_valid, in_data, mode, lock, out_ready,
                    input  in_ready, out_valid, out_data, out_sel);
    modport slave  (input  in_valid, in_data, mode, lock, out_ready,
                    output in_ready, out_valid, out_data, out_sel);
endinterface

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel arbitrated mux (round-robin or fixed priority, optional owner lock)
// feeding a one-entry registered output with valid/ready on both sides.
module rr_mux_arb #(
    parameter int W  = 5,
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_mux_arb_if.slave bus
);
    logic [SW-1:0] ptr_q, ptr_d, owner_q, owner_d, out_sel_q, out_sel_d, win;
    logic          owner_vld_q, owner_vld_d, out_valid_q, out_valid_d;
    logic          found, load, xfer;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [N-1:0]  grant;
    int            c;

    // A locked owner that still requests overrides both arbitration modes.
    always_comb begin
        win   = '0;
        found = 1'b0;
        c     = 0;
        if (bus.lock && owner_vld_q && bus.in_valid[owner_q]) begin
            win   = owner_q;
            found = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                c = bus.mode ? i : int'(ptr_q) + i;
                if (c >= N) c = c - N;
                if (!found && bus.in_valid[SW'(c)]) begin
                    win   = SW'(c);
                    found = 1'b1;
                end
            end
        end
    end

    assign load          = ~out_valid_q | bus.out_ready;
    assign grant         = found ? N'(1) << win : '0;
    assign xfer          = found & load;
    assign bus.in_ready  = grant & {N{load}};
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

    always_comb begin
        ptr_d       = (xfer && !bus.mode) ? ((win == SW'(N - 1)) ? '0 : win + 1'b1) : ptr_q;
        owner_d     = xfer ? win : owner_q;
        owner_vld_d = xfer | (bus.lock & owner_vld_q);
        out_valid_d = xfer | (out_valid_q & ~bus.out_ready);
        out_data_d  = xfer ? bus.in_data[int'(win) * W +: W] : out_data_q;
        out_sel_d   = xfer ? win : out_sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: random and directed stimulus on a 4x5 and a 3x8 instance,
// checked every cycle against a queue-free behavioural arbiter model.
module tb_rr_mux_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic done = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_ptr[2], m_own[2], m_ovld[2], m_ov[2], m_od[2], m_os[2];

    always #5 clk = ~clk;

    rr_mux_arb_if #(.W(5), .N(4), .SW(2)) a ();
    rr_mux_arb_if #(.W(8), .N(3), .SW(2)) b ();

    rr_mux_arb #(.W(5), .N(4), .SW(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    rr_mux_arb #(.W(8), .N(3), .SW(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input int n, input logic [15:0] v, input logic md,
                                input logic lk, input int p, input int ow, input int ov);
        if (lk && ov != 0 && v[ow]) return ow;
        for (int k = 0; k < n; k++) begin
            int ch;
            ch = md ? k : (p + k) % n;
            if (v[ch]) return ch;
        end
        return -1;
    endfunction

    task automatic step(input int u, input int n, input int w, input logic [15:0] v,
                        input logic [127:0] d, input logic md, input logic lk, input logic ordy,
                        input logic [15:0] ir, input logic ov, input logic [15:0] od,
                        input logic [3:0] os);
        int win;
        logic [15:0] er;
        if (!rst_n) begin
            m_ptr[u] = 0; m_own[u] = 0; m_ovld[u] = 0; m_ov[u] = 0; m_od[u] = 0; m_os[u] = 0;
            chk($sformatf("rst_out%0d", u), {11'd0, ov, od, os}, 32'd0);
            return;
        end
        chk($sformatf("out_valid%0d", u), {31'd0, ov}, m_ov[u]);
        chk($sformatf("out_data%0d", u), {16'd0, od}, m_od[u]);
        chk($sformatf("out_sel%0d", u), {28'd0, os}, m_os[u]);
        win = pick(n, v, md, lk, m_ptr[u], m_own[u], m_ovld[u]);
        er = (win >= 0 && (m_ov[u] == 0 || ordy)) ? 16'(1) << win : 16'd0;
        chk($sformatf("in_ready%0d", u), {16'd0, ir}, {16'd0, er});
        if (er != 0) begin
            m_od[u] = int'((d >> (win * w)) & ((128'(1) << w) - 1));
            m_os[u] = win;
            m_ov[u] = 1;
            if (!md) m_ptr[u] = (win + 1) % n;
            m_own[u] = win;
            m_ovld[u] = 1;
        end else begin
            if (ordy) m_ov[u] = 0;
            if (!lk) m_ovld[u] = 0;
        end
    endtask

    always @(negedge clk) begin
        step(0, 4, 5, 16'(a.in_valid), 128'(a.in_data), a.mode, a.lock, a.out_ready,
             16'(a.in_ready), a.out_valid, 16'(a.out_data), 4'(a.out_sel));
        step(1, 3, 8, 16'(b.in_valid), 128'(b.in_data), b.mode, b.lock, b.out_ready,
             16'(b.in_ready), b.out_valid, 16'(b.out_data), 4'(b.out_sel));
    end

    initial begin
        b.in_valid = '0; b.in_data = '0; b.mode = 1'b0; b.lock = 1'b0; b.out_ready = 1'b0;
        wait (rst_n);
        b.in_valid = 3'b111;
        b.in_data = {8'h30, 8'h20, 8'h10};
        b.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk("b_rr_sel", 32'(b.out_sel), j % 3);
            chk("b_rr_data", 32'(b.out_data), 32'h10 * (j % 3 + 1));
        end
        b.in_valid = 3'b001;
        cyc();
        chk("b_wrap_sel", 32'(b.out_sel), 0);
        while (!done) begin
            b.in_valid = 3'($urandom);
            b.in_data = 24'($urandom);
            b.mode = $urandom_range(0, 3) == 0;
            b.lock = 1'($urandom);
            b.out_ready = $urandom_range(0, 3) != 0;
            cyc();
        end
    end

    initial begin
        a.in_valid = '0; a.in_data = '0; a.mode = 1'b0; a.lock = 1'b0; a.out_ready = 1'b0;
        repeat (2) cyc();
        chk("reset_outputs", {a.out_valid, a.out_data, a.out_sel}, 32'd0);
        rst_n = 1'b1;
        a.in_valid = 4'b1111;
        a.in_data = {5'h04, 5'h03, 5'h02, 5'h01};
        a.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            chk("rr_sel", 32'(a.out_sel), j % 4);
            chk("rr_data", 32'(a.out_data), j % 4 + 1);
            chk("rr_ready", 32'(a.in_ready), 32'(1) << ((j + 1) % 4));
        end
        a.mode = 1'b1;
        a.in_valid = 4'b1010;
        repeat (3) begin
            cyc();
            chk("fixed_sel", 32'(a.out_sel), 1);
            chk("fixed_ready", 32'(a.in_ready), 32'b0010);
        end
        a.in_valid = 4'b1000;
        cyc();
        chk("fixed_drop_sel", 32'(a.out_sel), 3);
        a.in_valid = 4'b0100;
        a.in_data = {5'h04, 5'h1F, 5'h02, 5'h01};
        cyc();
        chk("bp_load", {a.out_sel, a.out_data}, {2'd2, 5'h1F});
        a.mode = 1'b0;
        a.in_valid = 4'b1111;
        a.out_ready = 1'b0;
        repeat (3) begin
            cyc();
            chk("bp_hold", {a.out_valid, a.out_data, a.in_ready}, {1'b1, 5'h1F, 4'b0000});
        end
        a.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(a.in_ready), 32'b0010);
        cyc();
        chk("bp_no_bubble", {a.out_valid, a.out_sel, a.out_data}, {1'b1, 2'd1, 5'h02});
        a.in_valid = 4'b0010;
        cyc();
        a.in_valid = 4'b1111;
        a.lock = 1'b1;
        repeat (3) begin
            cyc();
            chk("lock_hold", 32'(a.out_sel), 1);
        end
        a.in_valid = 4'b1101;
        cyc();
        chk("lock_drop", 32'(a.out_sel), 2);
        a.in_valid = 4'b1111;
        cyc();
        chk("lock_moved", 32'(a.out_sel), 2);
        a.lock = 1'b0;
        cyc();
        chk("unlock", 32'(a.out_sel), 3);
        repeat (400) begin
            a.in_valid = 4'($urandom);
            a.in_data = 20'($urandom);
            a.mode = $urandom_range(0, 3) == 0;
            a.lock = 1'($urandom);
            a.out_ready = $urandom_range(0, 3) != 0;
            cyc();
        end
        a.mode = 1'b0;
        a.lock = 1'b0;
        a.in_valid = 4'b1111;
        a.in_data = {5'h04, 5'h03, 5'h02, 5'h01};
        a.out_ready = 1'b0;
        cyc();
        chk("pre_reset_valid", 32'(a.out_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {a.out_valid, a.out_data, a.out_sel}, 32'd0);
        cyc();
        rst_n = 1'b1;
        a.out_ready = 1'b1;
        cyc();
        chk("restart_sel0", {a.out_valid, a.out_sel}, {1'b1, 2'd0});
        cyc();
        chk("restart_sel1", 32'(a.out_sel), 1);
        done = 1'b1;
        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
